// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle for stream_mux_nto1: N producer lanes in, one stream out.
// The mux takes the slave view; the surrounding fabric drives the master view.
interface stream_mux_nto1_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid
    );
endinterface

// File: rtl/stream_mux_nto1.sv
// N:1 registered stream mux, fixed-select or round-robin arbitration.
// Define STREAM_MUX_LOCK_EN to keep a channel granted until its in_last beat.
module stream_mux_nto1 #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [CW-1:0]   sel,
    stream_mux_nto1_if.slave bus
);
    logic          accept;
    logic          gnt_vld;
    logic [CW-1:0] gnt;
    logic          xfer;
    logic [W-1:0]  xdata;
    logic          xlast;
    logic          hold_ptr;
    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_nxt;

`ifdef STREAM_MUX_LOCK_EN
    logic          lock;
    logic [CW-1:0] lock_ch;
`else
    logic          unused_last;

    assign unused_last = ^{bus.in_last, xlast};
`endif

    assign accept  = !bus.out_valid || bus.out_ready;
    assign ptr_nxt = (gnt == CW'(N - 1)) ? '0 : gnt + 1'b1;

    // Reverse scan: the last hit is the first valid lane from ptr onward.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (!mode) begin
            if (int'(sel) < N) begin
                gnt_vld = 1'b1;
                gnt     = sel;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (bus.in_valid[(int'(ptr) + k) % N]) begin
                    gnt_vld = 1'b1;
                    gnt     = CW'((int'(ptr) + k) % N);
                end
            end
        end
`ifdef STREAM_MUX_LOCK_EN
        if (lock) begin
            gnt_vld = 1'b1;
            gnt     = lock_ch;
        end
`endif
    end

    always_comb begin
        bus.in_ready = '0;
        xfer         = 1'b0;
        xdata        = '0;
        xlast        = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (accept && gnt_vld && gnt == CW'(i)) begin
                bus.in_ready[i] = 1'b1;
                if (bus.in_valid[i]) begin
                    xfer  = 1'b1;
                    xdata = bus.in_data[i*W +: W];
                    xlast = bus.in_last[i];
                end
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    assign hold_ptr = lock && !xlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            lock    <= !xlast;
            lock_ch <= gnt;
        end
    end
`else
    assign hold_ptr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else if (accept) begin
            bus.out_valid <= xfer;
            if (xfer) begin
                bus.out_data <= xdata;
                bus.out_ch   <= gnt;
                if (mode && !hold_ptr) begin
                    ptr <= ptr_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: vector table, directed corners, random vs model.
// Expected lock behaviour follows STREAM_MUX_LOCK_EN.
module tb_stream_mux_nto1;
    logic       clk;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic       mode3;
    logic [1:0] sel3;

    int checks;
    int failures;

    stream_mux_nto1_if #(.N(4), .W(8)) bus ();
    stream_mux_nto1_if #(.N(3), .W(8)) bus3 ();

    stream_mux_nto1 #(.N(4), .W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .sel  (sel),
        .bus  (bus.slave)
    );

    stream_mux_nto1 #(.N(3), .W(8)) dut3 (
        .clk  (clk),
        .rst  (rst),
        .mode (mode3),
        .sel  (sel3),
        .bus  (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t tbl [9];

    // reference model state
    logic       m_ov;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    logic       m_lock;
    int         m_lch;

`ifdef STREAM_MUX_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Channel order of service: the lane list starting at the pointer.
    function automatic int model_grant(input logic md, input logic [1:0] s,
                                       input logic [3:0] v);
        int order [$];
        if (m_lock) return m_lch;
        if (!md) return (int'(s) < 4) ? int'(s) : -1;
        for (int k = 0; k < 4; k++) order.push_back((m_ptr + k) % 4);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic model_edge(input logic md, input logic [1:0] s,
                              input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic ordy);
        int g;
        g = model_grant(md, s, v);
        if (!m_ov || ordy) begin
            if (g >= 0 && v[g]) begin
                m_ov   = 1'b1;
                m_data = d[g*8 +: 8];
                m_ch   = g;
                if (md && !(m_lock && !l[g])) m_ptr = (g + 1) % 4;
                if (LOCK) begin
                    m_lock = !l[g];
                    m_lch  = g;
                end
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    initial begin
        int exp_seq [$];
        logic [3:0] exp_rdy;
        logic [3:0] v;
        logic [31:0] d;
        logic [3:0] l;
        logic       ordy;
        int g;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        mode     = 1'b1;
        sel      = 2'd0;
        mode3    = 1'b0;
        sel3     = 2'd0;
        bus.in_data   = 32'h40302010;
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        bus3.in_data  = 24'h030201;
        bus3.in_valid = 3'b000;
        bus3.in_last  = 3'b111;
        bus3.out_ready = 1'b1;

        tbl[0] = '{1'b0, 2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[1] = '{1'b0, 2'd0, 4'b1110, 4'b0001, 1'b0, 2'd0};
        tbl[2] = '{1'b0, 2'd3, 4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[3] = '{1'b1, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1};
        tbl[4] = '{1'b1, 2'd0, 4'b1010, 4'b1000, 1'b1, 2'd3};
        tbl[5] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[7] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0};
        tbl[8] = '{1'b0, 2'd1, 4'b0000, 4'b0010, 1'b0, 2'd0};

        // reset state
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        bus.in_valid = 4'b1111;
        #1;
        chk("rst_in_ready_rr", 32'(bus.in_ready), 32'b0001);

        // vector table
        for (int i = 0; i < 9; i++) begin
            mode = tbl[i].mode;
            sel  = tbl[i].sel;
            bus.in_valid = tbl[i].vld;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready),
                32'(tbl[i].exp_rdy));
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid),
                32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                chk($sformatf("tbl%0d_out_ch", i), 32'(bus.out_ch),
                    32'(tbl[i].exp_ch));
                chk($sformatf("tbl%0d_out_data", i), 32'(bus.out_data),
                    32'((tbl[i].exp_ch + 1) * 16));
            end
        end

        // fixed select streams one beat per clock
        mode = 1'b0;
        sel  = 2'd2;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fix_stream%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("fix_stream%0d_data", i), 32'(bus.out_data), 32'h30);
        end

        // round-robin wrap, then alternating on 1010
        do_reset();
        mode = 1'b1;
        bus.in_valid = 4'b1111;
        exp_seq = '{0, 1, 2, 3, 0, 1};
        foreach (exp_seq[i]) begin
            tick();
            chk($sformatf("rr_wrap%0d_ch", i), 32'(bus.out_ch), 32'(exp_seq[i]));
        end
        bus.in_valid = 4'b1010;
        exp_seq = '{3, 1, 3, 1};
        foreach (exp_seq[i]) begin
            tick();
            chk($sformatf("rr_alt%0d_ch", i), 32'(bus.out_ch), 32'(exp_seq[i]));
        end

        // backpressure, then no-bubble resume
        do_reset();
        mode = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_ch", i), 32'(bus.out_ch), 32'd0);
            chk($sformatf("bp%0d_data", i), 32'(bus.out_data), 32'h10);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'b0010);
        tick();
        chk("bp_release_ch", 32'(bus.out_ch), 32'd1);
        chk("bp_release_data", 32'(bus.out_data), 32'h20);

        // async reset mid-stream
        chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_async_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        chk("mid_rst_restart_ch", 32'(bus.out_ch), 32'd0);

        // packet lock
        do_reset();
        mode = 1'b1;
        bus.in_valid = 4'b0110;
        exp_seq = LOCK ? '{1, 1, 1, 2} : '{1, 2, 1, 2};
        for (int i = 0; i < 4; i++) begin
            bus.in_last = (i < 2) ? 4'b0100 : 4'b0110;
            tick();
            chk($sformatf("lock%0d_ch", i), 32'(bus.out_ch), 32'(exp_seq[i]));
        end
        bus.in_last = 4'b1111;

        // N=3: sel beyond last channel grants nothing
        bus3.in_valid = 3'b111;
        sel3 = 2'd0;
        tick();
        chk("n3_sel0_valid", 32'(bus3.out_valid), 32'd1);
        sel3 = 2'd3;
        #1;
        chk("n3_sel3_in_ready", 32'(bus3.in_ready), 32'd0);
        tick();
        chk("n3_sel3_valid", 32'(bus3.out_valid), 32'd0);

        // randomized against the model
        do_reset();
        m_ov = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        m_lock = 1'b0; m_lch = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel  = 2'($urandom_range(0, 3));
            v    = 4'($urandom);
            d    = $urandom;
            l    = 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            bus.in_valid  = v;
            bus.in_data   = d;
            bus.in_last   = l;
            bus.out_ready = ordy;
            #1;
            g = model_grant(mode, sel, v);
            exp_rdy = ((!m_ov || ordy) && g >= 0) ? 4'(1 << g) : 4'd0;
            chk($sformatf("rnd%0d_in_ready", c), 32'(bus.in_ready), 32'(exp_rdy));
            model_edge(mode, sel, v, d, l, ordy);
            tick();
            chk($sformatf("rnd%0d_valid", c), 32'(bus.out_valid), 32'(m_ov));
            if (m_ov) begin
                chk($sformatf("rnd%0d_ch", c), 32'(bus.out_ch), 32'(m_ch));
                chk($sformatf("rnd%0d_data", c), 32'(bus.out_data), 32'(m_data));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
